string_matcher_multi: RTL

Parametrised successor of the single-pattern string comparator in the packet-inspection path. It scans a byte stream for up to NUM_PATTERNS programmable strings and tracks which patterns matched. Window history is valid-qualified and is flushed at packet boundaries, so matches never span packets. Input data passes through with one-cycle latency, aligned with the match indications.

---
 rtl/string_matcher_multi.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/string_matcher_multi.sv
// Multi-pattern byte-stream matcher: up to NUM_PATTERNS programmable strings are
// searched over a valid-qualified sliding window that is flushed at packet ends.
module string_matcher_multi #(
  parameter int BYTES_PER_WORD = 4,
  parameter int MAX_LEN        = 17,
  parameter int NUM_PATTERNS   = 4,
  parameter int LEN_W          = 5,
  parameter int COUNT_W        = 16
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic                              clear,
  input  logic                              cfg_we,
  input  logic [$clog2(NUM_PATTERNS)-1:0]   cfg_idx,
  input  logic [MAX_LEN*8-1:0]              cfg_string,
  input  logic [LEN_W-1:0]                  cfg_len,
  input  logic                              data_valid,
  input  logic [BYTES_PER_WORD*8-1:0]       data_in,
  input  logic                              data_eop,
  output logic [BYTES_PER_WORD*8-1:0]       data_out,
  output logic                              data_out_valid,
  output logic                              match_pulse,
  output logic [NUM_PATTERNS-1:0]           match_vec,
  output logic [NUM_PATTERNS-1:0]           match_sticky,
  output logic [COUNT_W-1:0]                match_count
);
  localparam int HIST = MAX_LEN - 1;
  localparam int WIN  = HIST + BYTES_PER_WORD;

  logic [7:0]                  hist_q [HIST];
  logic [7:0]                  hist_d [HIST];
  logic [HIST-1:0]             hist_v_q, hist_v_d;
  logic [7:0]                  rpat_q [NUM_PATTERNS][MAX_LEN];
  logic [7:0]                  rpat_d [NUM_PATTERNS][MAX_LEN];
  logic [LEN_W-1:0]            len_q [NUM_PATTERNS];
  logic [LEN_W-1:0]            len_d [NUM_PATTERNS];
  logic [7:0]                  cfg_rpat [MAX_LEN];
  logic [7:0]                  win [WIN];
  logic [WIN-1:0]              win_v;
  logic [NUM_PATTERNS-1:0]     hits;

  logic [BYTES_PER_WORD*8-1:0] data_out_q, data_out_d;
  logic                        dov_q, dov_d;
  logic                        pulse_q, pulse_d;
  logic [NUM_PATTERNS-1:0]     vec_q, vec_d;
  logic [NUM_PATTERNS-1:0]     sticky_q, sticky_d;
  logic [COUNT_W-1:0]          count_q, count_d;
  logic                        new_pkt_q, new_pkt_d;

  // Stream order: win[0] is oldest, win[WIN-1] is the last byte of the current word.
  for (genvar gi = 0; gi < HIST; gi++) begin : g_hist
    assign win[gi]   = hist_q[gi];
    assign win_v[gi] = hist_v_q[gi];
  end
  for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_word
    assign win[HIST+gi]   = data_in[(BYTES_PER_WORD-1-gi)*8 +: 8];
    assign win_v[HIST+gi] = 1'b1;
  end

  // Patterns are stored reversed (rpat[j] = byte L-1-j) so each end position
  // compares against fixed window offsets regardless of pattern length.
  always_comb begin
    for (int j = 0; j < MAX_LEN; j++) begin
      cfg_rpat[j] = 8'h00;
      if (j < int'(cfg_len) && int'(cfg_len) <= MAX_LEN)
        cfg_rpat[j] = cfg_string[(MAX_LEN - int'(cfg_len) + j)*8 +: 8];
    end
  end

  for (genvar gi = 0; gi < NUM_PATTERNS; gi++) begin : g_pat
    logic hit;
    always_comb begin
      hit = 1'b0;
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        logic ok;
        ok = (len_q[gi] != '0) && (int'(len_q[gi]) <= MAX_LEN);
        for (int j = 0; j < MAX_LEN; j++) begin
          if (j < int'(len_q[gi])) begin
            if (!win_v[HIST+k-j] || (win[HIST+k-j] != rpat_q[gi][j]))
              ok = 1'b0;
          end
        end
        hit = hit | ok;
      end
    end
    assign hits[gi] = hit;
  end

  always_comb begin
    hist_d     = hist_q;
    hist_v_d   = hist_v_q;
    rpat_d     = rpat_q;
    len_d      = len_q;
    data_out_d = data_out_q;
    dov_d      = 1'b0;
    vec_d      = '0;
    sticky_d   = sticky_q;
    count_d    = count_q;
    new_pkt_d  = new_pkt_q;

    if (clear) begin
      for (int j = 0; j < HIST; j++) hist_d[j] = 8'h00;
      hist_v_d   = '0;
      data_out_d = '0;
      sticky_d   = '0;
      count_d    = '0;
      new_pkt_d  = 1'b0;
    end else if (data_valid) begin
      for (int j = 0; j < HIST; j++) begin
        hist_d[j]   = win[j+BYTES_PER_WORD];
        hist_v_d[j] = win_v[j+BYTES_PER_WORD] & ~data_eop;
      end
      data_out_d = data_in;
      dov_d      = 1'b1;
      vec_d      = hits;
      sticky_d   = (new_pkt_q ? '0 : sticky_q) | hits;
      if (|hits && (count_q != '1))
        count_d = count_q + 1'b1;
      new_pkt_d  = data_eop;
    end

    if (cfg_we) begin
      len_d[cfg_idx]  = cfg_len;
      rpat_d[cfg_idx] = cfg_rpat;
    end
    pulse_d = |vec_d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int j = 0; j < HIST; j++) hist_q[j] <= 8'h00;
      for (int p = 0; p < NUM_PATTERNS; p++) begin
        len_q[p] <= '0;
        for (int j = 0; j < MAX_LEN; j++) rpat_q[p][j] <= 8'h00;
      end
      hist_v_q   <= '0;
      data_out_q <= '0;
      dov_q      <= 1'b0;
      pulse_q    <= 1'b0;
      vec_q      <= '0;
      sticky_q   <= '0;
      count_q    <= '0;
      new_pkt_q  <= 1'b0;
    end else begin
      hist_q     <= hist_d;
      hist_v_q   <= hist_v_d;
      rpat_q     <= rpat_d;
      len_q      <= len_d;
      data_out_q <= data_out_d;
      dov_q      <= dov_d;
      pulse_q    <= pulse_d;
      vec_q      <= vec_d;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
      new_pkt_q  <= new_pkt_d;
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = dov_q;
  assign match_pulse    = pulse_q;
  assign match_vec      = vec_q;
  assign match_sticky   = sticky_q;
  assign match_count    = count_q;
endmodule
